// File: rtl/uart_tx_fifo_wb_pkg.sv
// Shared definitions for the Wishbone UART transmitter: FSM states,
// register offsets and STATUS field positions.
package uart_tx_fifo_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int   ADR_SEL_BIT  = 2;
    localparam logic ADR_DATA     = 1'b0;
    localparam logic ADR_STATUS   = 1'b1;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 4;

    function automatic logic [31:0] status_word(
        input logic [7:0] count,
        input logic       ovf,
        input logic       busy,
        input logic       full,
        input logic       empty
    );
        logic [31:0] w;
        w = '0;
        w[ST_COUNT_LSB +: 8] = count;
        w[ST_OVF_BIT]        = ovf;
        w[ST_BUSY_BIT]       = busy;
        w[ST_FULL_BIT]       = full;
        w[ST_EMPTY_BIT]      = empty;
        return w;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Circular byte FIFO with wrapping pointers and an explicit occupancy count.
// Full/empty come from the registered count, so a push on a full FIFO is dropped even if a pop happens on the same edge.
module tx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [7:0]          din,
    input  logic                pop,
    output logic [7:0]          dout,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo_wb.sv
// Wishbone slave UART transmitter: DATA register feeds a byte FIFO,
// an 8N1 serializer drains it onto o_tx, STATUS exposes FIFO/line state.
module uart_tx_fifo_wb #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [2:0]  i_wb_adr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_fifo_full
);

    import uart_tx_fifo_wb_pkg::*;

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    logic                ack_q, ack_d;
    logic [31:0]         rdt_q, rdt_d;
    logic                ovf_q, ovf_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    tx_state_e           state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_q, bit_d;
    logic [BW-1:0]       baud_q, baud_d;

    logic                req;
    logic                is_status;
    logic                wr_data;
    logic                rd_status;
    logic                ovf_set;
    logic                fifo_pop;
    logic [7:0]          fifo_dout;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                unused_bits;

    assign unused_bits = ^{i_wb_dat[31:8], i_wb_sel[3:1], i_wb_adr[1:0]};

    // Side effects only on the edge that raises ack.
    assign req       = i_wb_cyc & ~ack_q;
    assign is_status = (i_wb_adr[ADR_SEL_BIT] == ADR_STATUS);
    assign wr_data   = req & i_wb_we & ~is_status & i_wb_sel[0];
    assign rd_status = req & ~i_wb_we & is_status;
    assign ovf_set   = wr_data & fifo_full;

    tx_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (i_wb_clk),
        .rst   (i_wb_rst),
        .push  (wr_data),
        .din   (i_wb_dat[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ack_d = i_wb_cyc & ~ack_q;
        rdt_d = '0;
        ovf_d = ovf_q;
        if (rd_status) begin
            rdt_d = status_word(8'(fifo_count), ovf_q, busy_q,
                                fifo_full, fifo_empty);
            ovf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = '0;
                    baud_d   = BAUD_MAX;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) state_d = ST_IDLE;
                else              baud_d  = baud_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line and busy are registered from the current state, one cycle behind it.
    always_comb begin
        busy_d = (state_q != ST_IDLE);
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            ack_q   <= 1'b0;
            rdt_q   <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_rdt    = rdt_q;
    assign o_tx        = tx_q;
    assign o_busy      = busy_q;
    assign o_fifo_full = fifo_full;

endmodule
